// File: rtl/ddr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_arb_pkg
// Purpose  : Shared constants and FSM encoding for the DDR read arbiter.
// Revision : 1.0  initial release
// ============================================================================
package ddr_arb_pkg;
    localparam int NUM_REQ                 = 2;
    localparam int TAG_W                   = 1;
    localparam int MAX_OUTSTANDING_DEFAULT = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;
endpackage
`default_nettype wire

// File: rtl/arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : arb_tag_fifo
// Purpose  : Requester-tag FIFO; remembers who owns each outstanding DDR read.
// Revision : 1.0  initial release
// ============================================================================
module arb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/ddr_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr_read_arbiter
// Purpose  : Round-robin arbiter sharing one pipelined DDR read port between
//            two requesters, with in-order tagged return routing.
// Revision : 1.0  initial release
// ============================================================================
module ddr_read_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_read,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_waitrequest,
    output logic [DATA_W-1:0] r0_readdata,
    output logic              r0_readdatavalid,
    input  logic              r1_read,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_waitrequest,
    output logic [DATA_W-1:0] r1_readdata,
    output logic              r1_readdatavalid,
    output logic [ADDR_W-1:0] ddr_addr,
    output logic              ddr_read,
    input  logic              ddr_waitrequest,
    input  logic [DATA_W-1:0] ddr_readdata,
    input  logic              ddr_readdatavalid,
    output logic [2:0]        outstanding,
    output logic              err_unexpected
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_addr_next;
    logic [TAG_W-1:0]  cmd_id;
    logic [TAG_W-1:0]  cmd_id_next;
    logic [TAG_W-1:0]  last_grant;
    logic [TAG_W-1:0]  last_grant_next;
    logic [TAG_W-1:0]  grant_id;
    logic              accept;

    logic              tag_push;
    logic              tag_pop;
    logic [TAG_W-1:0]  pop_tag;
    logic [CNT_W-1:0]  tag_count;
    logic              tag_empty;
    logic              tag_full;

    // Contention goes to whoever was not served last; a lone requester wins outright.
    always_comb begin
        if (r0_read && r1_read) begin
            grant_id = ~last_grant;
        end else if (r0_read) begin
            grant_id = TAG_W'(0);
        end else begin
            grant_id = TAG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd_addr   <= '0;
            cmd_id     <= '0;
            last_grant <= TAG_W'(1);
        end else begin
            state      <= state_next;
            cmd_addr   <= cmd_addr_next;
            cmd_id     <= cmd_id_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        cmd_addr_next   = cmd_addr;
        cmd_id_next     = cmd_id;
        last_grant_next = last_grant;
        accept          = 1'b0;
        case (state)
            IDLE: begin
                // Registered count: a return in this same cycle frees a slot only next cycle.
                if ((r0_read || r1_read) && !tag_full) begin
                    cmd_id_next   = grant_id;
                    cmd_addr_next = (grant_id == TAG_W'(0)) ? r0_addr : r1_addr;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                if (!ddr_waitrequest) begin
                    accept          = 1'b1;
                    last_grant_next = cmd_id;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ddr_read       = (state == ISSUE) && !reset;
    assign ddr_addr       = cmd_addr;
    assign tag_push       = accept && !reset;
    assign r0_waitrequest = !(tag_push && (cmd_id == TAG_W'(0)));
    assign r1_waitrequest = !(tag_push && (cmd_id == TAG_W'(1)));
    assign tag_pop        = ddr_readdatavalid && !tag_empty;
    assign outstanding    = 3'(tag_count);

    arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tag_push),
        .push_data (cmd_id),
        .pop       (tag_pop),
        .pop_data  (pop_tag),
        .count     (tag_count),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r0_readdata      <= '0;
            r1_readdata      <= '0;
            r0_readdatavalid <= 1'b0;
            r1_readdatavalid <= 1'b0;
            err_unexpected   <= 1'b0;
        end else begin
            r0_readdatavalid <= tag_pop && (pop_tag == TAG_W'(0));
            r1_readdatavalid <= tag_pop && (pop_tag == TAG_W'(1));
            if (tag_pop && (pop_tag == TAG_W'(0))) begin
                r0_readdata <= ddr_readdata;
            end
            if (tag_pop && (pop_tag == TAG_W'(1))) begin
                r1_readdata <= ddr_readdata;
            end
            if (ddr_readdatavalid && tag_empty) begin
                err_unexpected <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ddr_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_read_arbiter
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            checked every cycle against a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ddr_read_arbiter;
    localparam int MAXO = 4;
    localparam int AW   = 16;
    localparam int DW   = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          r0_read = 1'b0, r1_read = 1'b0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic          r0_waitrequest, r1_waitrequest;
    logic [DW-1:0] r0_readdata, r1_readdata;
    logic          r0_readdatavalid, r1_readdatavalid;
    logic [AW-1:0] ddr_addr;
    logic          ddr_read;
    logic          ddr_waitrequest = 1'b0;
    logic [DW-1:0] ddr_readdata = '0;
    logic          ddr_readdatavalid = 1'b0;
    logic [2:0]    outstanding;
    logic          err_unexpected;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddr_read_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .ADDR_W          (AW),
        .DATA_W          (DW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .r0_read           (r0_read),
        .r0_addr           (r0_addr),
        .r0_waitrequest    (r0_waitrequest),
        .r0_readdata       (r0_readdata),
        .r0_readdatavalid  (r0_readdatavalid),
        .r1_read           (r1_read),
        .r1_addr           (r1_addr),
        .r1_waitrequest    (r1_waitrequest),
        .r1_readdata       (r1_readdata),
        .r1_readdatavalid  (r1_readdatavalid),
        .ddr_addr          (ddr_addr),
        .ddr_read          (ddr_read),
        .ddr_waitrequest   (ddr_waitrequest),
        .ddr_readdata      (ddr_readdata),
        .ddr_readdatavalid (ddr_readdatavalid),
        .outstanding       (outstanding),
        .err_unexpected    (err_unexpected)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending command slot plus a queue of owner tags.
    int            q[$];
    bit            m_busy = 1'b0;
    int            m_id = 0;
    logic [AW-1:0] m_addr = '0;
    int            m_last = 1;
    logic [DW-1:0] m_data [2] = '{default: '0};
    bit   [1:0]    m_valid = '0;
    bit            m_err = 1'b0;
    int            m_sz;
    int            m_t;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_busy  = 1'b0;
            m_id    = 0;
            m_addr  = '0;
            m_last  = 1;
            m_data  = '{default: '0};
            m_valid = '0;
            m_err   = 1'b0;
        end else begin
            m_sz    = q.size();
            m_valid = '0;
            if (ddr_readdatavalid) begin
                if (m_sz > 0) begin
                    m_t            = q.pop_front();
                    m_valid[m_t]   = 1'b1;
                    m_data[m_t]    = ddr_readdata;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_busy) begin
                if (!ddr_waitrequest) begin
                    q.push_back(m_id);
                    m_last = m_id;
                    m_busy = 1'b0;
                end
            end else if ((r0_read || r1_read) && m_sz < MAXO) begin
                m_id   = (r0_read && r1_read) ? 1 - m_last : (r0_read ? 0 : 1);
                m_addr = (m_id == 1) ? r1_addr : r0_addr;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("ddr_read", 32'(ddr_read), 32'(m_busy));
            chk("ddr_addr", 32'(ddr_addr), 32'(m_addr));
            chk("r0_waitrequest", 32'(r0_waitrequest), 32'(!(m_busy && !ddr_waitrequest && m_id == 0)));
            chk("r1_waitrequest", 32'(r1_waitrequest), 32'(!(m_busy && !ddr_waitrequest && m_id == 1)));
            chk("r0_readdatavalid", 32'(r0_readdatavalid), 32'(m_valid[0]));
            chk("r1_readdatavalid", 32'(r1_readdatavalid), 32'(m_valid[1]));
            chk("r0_readdata", 32'(r0_readdata), 32'(m_data[0]));
            chk("r1_readdata", 32'(r1_readdata), 32'(m_data[1]));
            chk("outstanding", 32'(outstanding), 32'(q.size()));
            chk("err_unexpected", 32'(err_unexpected), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset             = 1'b1;
        r0_read           = 1'b0;
        r1_read           = 1'b0;
        ddr_waitrequest   = 1'b0;
        ddr_readdatavalid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic ddr_return(input logic [DW-1:0] d);
        ddr_readdatavalid = 1'b1;
        ddr_readdata      = d;
        tick();
        ddr_readdatavalid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            n;
        int            acc;
        bit            got;
        bit            a0, a1;
        logic [AW-1:0] seq [4];

        seq[0] = 16'h0100; seq[1] = 16'h0200; seq[2] = 16'h0100; seq[3] = 16'h0200;

        // Reset values
        apply_reset();
        @(negedge clk);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_wait0", 32'(r0_waitrequest), 32'd1);
        chk("rst_ddr_read", 32'(ddr_read), 32'd0);
        chk("rst_ddr_addr", 32'(ddr_addr), 32'd0);
        chk("rst_err", 32'(err_unexpected), 32'd0);

        // Single read from r0, data three cycles after acceptance
        tick();
        r0_read = 1'b1; r0_addr = 16'h0010;
        @(negedge clk); chk("t1_wait_pre", 32'(r0_waitrequest), 32'd1);
        @(negedge clk);
        chk("t1_wait_acc", 32'(r0_waitrequest), 32'd0);
        chk("t1_ddr_addr", 32'(ddr_addr), 32'h0010);
        chk("t1_ddr_read", 32'(ddr_read), 32'd1);
        chk("t1_r1_wait", 32'(r1_waitrequest), 32'd1);
        tick(); r0_read = 1'b0;
        @(negedge clk);
        chk("t1_wait_post", 32'(r0_waitrequest), 32'd1);
        chk("t1_outstanding", 32'(outstanding), 32'd1);
        tick(); tick();
        ddr_return(16'hA5A5);
        @(negedge clk);
        chk("t1_r0_valid", 32'(r0_readdatavalid), 32'd1);
        chk("t1_r0_data", 32'(r0_readdata), 32'hA5A5);
        chk("t1_r1_valid", 32'(r1_readdatavalid), 32'd0);
        @(negedge clk);
        chk("t1_r0_valid_end", 32'(r0_readdatavalid), 32'd0);
        chk("t1_r0_data_hold", 32'(r0_readdata), 32'hA5A5);

        // Both requesters held: strict alternation starting with r0
        apply_reset();
        r0_read = 1'b1; r0_addr = 16'h0100;
        r1_read = 1'b1; r1_addr = 16'h0200;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (ddr_read && !ddr_waitrequest) begin
                chk("t2_ddr_addr", 32'(ddr_addr), 32'(seq[n]));
                n++;
            end
        end
        chk("t2_accepts", 32'(n), 32'd4);
        tick(); r0_read = 1'b0; r1_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ddr_return(16'(16'h0011 + k));
            @(negedge clk);
            chk("t2_r0_valid", 32'(r0_readdatavalid), 32'((k % 2) == 0));
            chk("t2_r1_valid", 32'(r1_readdatavalid), 32'((k % 2) == 1));
            chk("t2_data", 32'((k % 2 == 0) ? r0_readdata : r1_readdata), 32'(16'h0011 + k));
        end

        // Outstanding limit: fifth read stalls until a return frees a slot
        apply_reset();
        r0_read = 1'b1; r0_addr = 16'h3000;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!r0_waitrequest) acc++;
            tick();
        end
        chk("t3_accepts", 32'(acc), 32'd4);
        @(negedge clk);
        chk("t3_outstanding", 32'(outstanding), 32'd4);
        chk("t3_wait_full", 32'(r0_waitrequest), 32'd1);
        tick();
        ddr_return(16'h0001);
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (!r0_waitrequest) got = 1'b1;
        end
        chk("t3_fifth_accepted", 32'(got), 32'd1);
        tick(); r0_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ddr_return(16'(k));
        end
        @(negedge clk);
        chk("t3_drained", 32'(outstanding), 32'd0);

        // DDR stall during ISSUE
        tick();
        ddr_waitrequest = 1'b1;
        r0_read = 1'b1; r0_addr = 16'h0BEE;
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t4_stall_read", 32'(ddr_read), 32'd1);
            chk("t4_stall_addr", 32'(ddr_addr), 32'h0BEE);
            chk("t4_stall_wait", 32'(r0_waitrequest), 32'd1);
        end
        tick(); ddr_waitrequest = 1'b0;
        @(negedge clk);
        chk("t4_accept7", 32'(r0_waitrequest), 32'd0);
        tick(); r0_read = 1'b0;
        ddr_return(16'h5A5A);
        @(negedge clk);
        chk("t4_return", 32'(r0_readdata), 32'h5A5A);

        // Unexpected return with nothing outstanding
        apply_reset();
        ddr_return(16'hDEAD);
        @(negedge clk);
        chk("t5_r0_valid", 32'(r0_readdatavalid), 32'd0);
        chk("t5_r1_valid", 32'(r1_readdatavalid), 32'd0);
        chk("t5_err", 32'(err_unexpected), 32'd1);
        tick(); tick(); tick();
        @(negedge clk);
        chk("t5_err_sticky", 32'(err_unexpected), 32'd1);
        apply_reset();
        @(negedge clk);
        chk("t5_err_cleared", 32'(err_unexpected), 32'd0);

        // Reset with two reads in flight discards their tags
        tick();
        r0_read = 1'b1; r0_addr = 16'h0A00;
        r1_read = 1'b1; r1_addr = 16'h0B00;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clk);
            a0 = r0_read && !r0_waitrequest;
            a1 = r1_read && !r1_waitrequest;
            tick();
            if (a0) begin r0_read = 1'b0; n++; end
            if (a1) begin r1_read = 1'b0; n++; end
        end
        @(negedge clk);
        chk("t6_outstanding2", 32'(outstanding), 32'd2);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_outstanding0", 32'(outstanding), 32'd0);
        chk("t6_err_clear", 32'(err_unexpected), 32'd0);
        for (int k = 0; k < 2; k++) begin
            ddr_return(16'(16'h0E00 + k));
            @(negedge clk);
            chk("t6_no_valid", 32'(r0_readdatavalid | r1_readdatavalid), 32'd0);
            chk("t6_err", 32'(err_unexpected), 32'd1);
        end

        // Randomized traffic, checked by the model every cycle
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            a0 = r0_read && !r0_waitrequest;
            a1 = r1_read && !r1_waitrequest;
            tick();
            if (!r0_read || a0) begin
                r0_read = ($urandom_range(0, 2) != 0);
                r0_addr = 16'($urandom);
            end else if ($urandom_range(0, 40) == 0) begin
                r0_read = 1'b0;
            end
            if (!r1_read || a1) begin
                r1_read = ($urandom_range(0, 2) != 0);
                r1_addr = 16'($urandom);
            end else if ($urandom_range(0, 40) == 0) begin
                r1_read = 1'b0;
            end
            ddr_waitrequest   = ($urandom_range(0, 3) == 0);
            ddr_readdatavalid = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            ddr_readdata      = 16'($urandom);
        end
        r0_read = 1'b0; r1_read = 1'b0;
        ddr_waitrequest = 1'b0; ddr_readdatavalid = 1'b0;
        tick(); tick();
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            ddr_return(16'($urandom));
        end
        @(negedge clk);
        chk("rand_drained", 32'(outstanding), 32'd0);
        chk("rand_no_err", 32'(err_unexpected), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ddr_read_arbiter.md
DDR_READ_ARBITER -- requirements
Module: ddr_read_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4: maximum DDR reads issued but not yet returned.
REQ-002 Parameter ADDR_W, default 16: DDR word address width.
REQ-003 Parameter DATA_W, default 16: DDR read data width.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 rN_read  input  1  (N=0,1) requester N read request; held until accepted.
REQ-007 rN_addr  input  ADDR_W  requester N word address; stable while rN_read=1.
REQ-008 rN_waitrequest  output  1  requester N stall; 0 for exactly the acceptance cycle.
REQ-009 rN_readdata  output  DATA_W  return data for requester N.
REQ-010 rN_readdatavalid  output  1  one-cycle pulse qualifying rN_readdata.
REQ-011 ddr_addr  output  ADDR_W  shared DDR port address.
REQ-012 ddr_read  output  1  shared DDR port read strobe.
REQ-013 ddr_waitrequest  input  1  DDR port stall.
REQ-014 ddr_readdata  input  DATA_W  DDR return data.
REQ-015 ddr_readdatavalid  input  1  DDR return qualifier, in-order w.r.t. accepted reads.
REQ-016 outstanding  output  3  count of accepted, unreturned reads (0..MAX_OUTSTANDING).
REQ-017 err_unexpected  output  1  sticky: DDR returned data with no read outstanding.

Function
REQ-018 FSM states SHALL be IDLE and ISSUE.
REQ-019 IDLE: if any rN_read=1 and outstanding<MAX_OUTSTANDING, SHALL latch grant id and rN_addr, then go to ISSUE; else stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: if both requesters request, grant the one not last granted; a single requester is granted directly.
REQ-021 ISSUE: ddr_read=1 and ddr_addr=latched address; stay while ddr_waitrequest=1.
REQ-022 ISSUE with ddr_waitrequest=0: rG_waitrequest=0 (combinational, same cycle), push grant id into tag FIFO, update last-granted, return to IDLE.
REQ-023 Non-granted requester, and any requester outside the acceptance cycle, SHALL see rN_waitrequest=1.
REQ-024 Command throughput SHALL be one accepted read per 2 cycles at most (IDLE->ISSUE->IDLE).
REQ-025 On ddr_readdatavalid=1 with FIFO non-empty: pop tag T; next cycle rT_readdata=ddr_readdata and rT_readdatavalid=1; other requester's valid=0 (latency 1 cycle).
REQ-026 rN_readdata SHALL hold its last value when valid=0.
REQ-027 Simultaneous push and pop in one cycle: both SHALL occur; outstanding unchanged.
REQ-028 Outstanding=MAX_OUTSTANDING: no grant; a pop in the same cycle SHALL NOT enable a grant until the following cycle.
REQ-029 ddr_readdatavalid=1 with FIFO empty: data dropped, no rN_readdatavalid, err_unexpected set to 1 until reset.
REQ-030 Requester dropping rN_read while granted SHALL NOT abort the latched command; it completes and the data is returned.
REQ-031 Tag FIFO pointers SHALL wrap modulo MAX_OUTSTANDING; order of returns SHALL equal order of acceptance.

Reset
REQ-032 reset=1 SHALL force: state IDLE, last-granted=1 (requester 0 wins first), FIFO empty, outstanding=0, err_unexpected=0, ddr_read=0, ddr_addr=0, rN_readdata=0, rN_readdatavalid=0, rN_waitrequest=1.
REQ-033 Reset mid-transaction SHALL discard the in-flight command and all tags; later DDR returns SHALL set err_unexpected.

Structure
REQ-034 Package ddr_arb_pkg SHALL hold NUM_REQ=2, TAG_W=1, the default MAX_OUTSTANDING, and the state encoding (IDLE=0, ISSUE=1).
REQ-035 Tag FIFO SHALL be a sub-module arb_tag_fifo (depth MAX_OUTSTANDING, width TAG_W, push/pop/count/empty/full).

Verification
REQ-036 r0 reads 0x0010, ddr_waitrequest=0, data 0xA5A5 returned 3 cycles later -> r0_waitrequest low 1 cycle, r0_readdatavalid pulse with 0xA5A5, r1 sees nothing.
REQ-037 r0 and r1 held continuously, addrs 0x0100/0x0200 -> ddr_addr sequence 0x0100,0x0200,0x0100,0x0200; returns routed in that order.
REQ-038 DDR never returns; r0 issues 5 reads -> 4 accepted, outstanding=4, 5th held with r0_waitrequest=1 until one return, then accepted.
REQ-039 ddr_waitrequest=1 for 6 cycles during ISSUE -> ddr_addr/ddr_read stable, no acceptance; accepted on cycle 7.
REQ-040 ddr_readdatavalid pulse with outstanding=0 -> no rN_readdatavalid, err_unexpected=1 until reset.
REQ-041 reset asserted with 2 outstanding -> outstanding=0; subsequent 2 DDR returns set err_unexpected, no requester valid.
